// File: rtl/dcache_lsu.sv
// rtl/dcache_lsu.sv - load/store unit driving a single-port word dcache
// Handles byte/half/word loads with extension and sub-word stores via read-modify-write.
module dcache_lsu #(
  parameter int DEPTH = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] cache_addr,
  output logic [31:0] cache_wr_data,
  output logic        cache_wr_en,
  input  logic [31:0] cache_rd_data
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [1:0]  lane_q, lane_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic [15:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] wr_data_q, wr_data_d;

  logic        misaligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] merged;

  // Bits above the word index are dropped so the index wraps modulo DEPTH.
  logic unused_addr;
  assign unused_addr = ^req_addr[31:IW+2];

  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));

  always_comb begin
    byte_sel = 8'h00;
    case (lane_q)
      2'd0:    byte_sel = cache_rd_data[7:0];
      2'd1:    byte_sel = cache_rd_data[15:8];
      2'd2:    byte_sel = cache_rd_data[23:16];
      default: byte_sel = cache_rd_data[31:24];
    endcase
    half_sel = lane_q[1] ? cache_rd_data[31:16] : cache_rd_data[15:0];

    load_val = cache_rd_data;
    if (size_q == 2'b00)
      load_val = {{24{~uns_q & byte_sel[7]}}, byte_sel};
    else if (size_q == 2'b01)
      load_val = {{16{~uns_q & half_sel[15]}}, half_sel};

    merged = cache_rd_data;
    if (size_q == 2'b00)
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    lane_d    = lane_q;
    size_d    = size_q;
    we_d      = we_q;
    uns_d     = uns_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    wr_data_d = wr_data_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          idx_d   = req_addr[IW+1:2];
          lane_d  = req_addr[1:0];
          size_d  = req_size;
          we_d    = req_we;
          uns_d   = req_unsigned;
          wdata_d = req_wdata[15:0];
          err_d   = misaligned;
          rdata_d = 32'h0;
          if (misaligned) begin
            state_d = DONE;
          end else if (req_we && req_size[1]) begin
            wr_data_d = req_wdata;
            state_d   = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (we_q) begin
          wr_data_d = merged;
          state_d   = WRITE;
        end else begin
          rdata_d = load_val;
          state_d = DONE;
        end
      end
      WRITE:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      lane_q    <= 2'b00;
      size_q    <= 2'b00;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      wdata_q   <= 16'h0;
      err_q     <= 1'b0;
      rdata_q   <= 32'h0;
      wr_data_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      lane_q    <= lane_d;
      size_q    <= size_d;
      we_q      <= we_d;
      uns_q     <= uns_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign resp_valid    = (state_q == DONE);
  assign resp_err      = (state_q == DONE) && err_q;
  assign resp_rdata    = rdata_q;
  assign cache_addr    = {{(32-IW){1'b0}}, idx_q};
  assign cache_wr_data = wr_data_q;
  // Decoded from the state register, so an asynchronous reset kills the strobe at once.
  assign cache_wr_en   = (state_q == WRITE);

endmodule
